// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: loader FSM states,
// instruction constants and the byte-assembly geometry.
package if_fetch_stage_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2
   } fetch_state_t;

   localparam logic [31:0] HALT_INSTR     = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
   localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/if_fetch_stage_loader.sv
// Program loader: assembles MSB-first bytes from the debug UART into words,
// walks the write pointer through instruction memory and owns the
// IDLE/LOAD/RUN sequencing of the fetch stage.
module if_fetch_stage_loader
   import if_fetch_stage_pkg::*;
#(
   parameter int               NBITS     = 32,
   parameter int               MEM_DEPTH = 256,
   parameter int               ADDR_W    = 8,
   parameter logic [NBITS-1:0] HALT_WORD = HALT_INSTR
)(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_load_start,
   input  logic              i_load_valid,
   input  logic [7:0]        i_load_byte,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_waddr,
   output logic [NBITS-1:0]  o_wdata,
   output fetch_state_t      o_state,
   output logic              o_load_done,
   output logic              o_loading
);

   localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_WORD - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] wptr_q;
   logic [1:0]        bcnt_q;
   // Only the three most recent bytes are kept; the fourth completes the word.
   logic [NBITS-9:0]  sr_q;
   logic [NBITS-1:0]  word_asm;
   logic              word_done;
   logic              load_finish;
   logic              load_done_q;

   assign word_asm = {sr_q, i_load_byte};

   // Next-state logic; a load start in any state restarts the load and wins
   // over a byte strobe arriving in the same cycle.
   always_comb begin
      state_d     = state_q;
      load_finish = 1'b0;
      word_done   = (state_q == S_LOAD) && i_load_valid && !i_load_start
                    && (bcnt_q == LAST_BYTE);
      if (i_load_start) begin
         state_d = S_LOAD;
      end else if (word_done && ((word_asm == HALT_WORD) || (wptr_q == LAST_ADDR))) begin
         state_d     = S_RUN;
         load_finish = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Byte assembler, write pointer and the one-cycle done pulse.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wptr_q      <= '0;
         bcnt_q      <= '0;
         sr_q        <= '0;
         load_done_q <= 1'b0;
      end else begin
         load_done_q <= load_finish;
         if (i_load_start) begin
            wptr_q <= '0;
            bcnt_q <= '0;
         end else if (state_q == S_LOAD && i_load_valid) begin
            sr_q <= word_asm[NBITS-9:0];
            if (bcnt_q == LAST_BYTE) begin
               bcnt_q <= '0;
               wptr_q <= wptr_q + 1'b1;
            end else begin
               bcnt_q <= bcnt_q + 1'b1;
            end
         end
      end
   end

   // The full word is written in the same cycle its last byte arrives.
   assign o_we        = word_done;
   assign o_waddr     = wptr_q;
   assign o_wdata     = word_asm;
   assign o_state     = state_q;
   assign o_load_done = load_done_q;
   assign o_loading   = (state_q == S_LOAD);

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: instruction memory with loader write port,
// next-PC selection and the IF/ID pipeline register.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter int               NBITS     = 32,
   parameter int               MEM_DEPTH = 256,
   parameter int               ADDR_W    = 8,
   parameter logic [NBITS-1:0] HALT_WORD = HALT_INSTR
)(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic             i_halt,
   input  logic             i_stall,
   input  logic             i_flush,
   input  logic [NBITS-1:0] i_pc,
   input  logic             i_branch_taken,
   input  logic [NBITS-1:0] i_branch_target,
   input  logic             i_load_start,
   input  logic             i_load_valid,
   input  logic [7:0]       i_load_byte,
   output logic [NBITS-1:0] o_next_pc,
   output logic [NBITS-1:0] o_instr,
   output logic [NBITS-1:0] o_pc_plus1,
   output logic             o_valid,
   output logic             o_halt_fetched,
   output logic             o_load_done,
   output logic             o_loading
);

   logic [NBITS-1:0]  mem [MEM_DEPTH];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [NBITS-1:0]  mem_wdata;
   logic [NBITS-1:0]  rd_word;
   fetch_state_t      state;

   logic              run_ok;
   logic              advance;
   logic              flush_ok;
   logic [NBITS-1:0]  pc_plus1;

   logic [NBITS-1:0]  instr_p1;
   logic [NBITS-1:0]  pc_plus1_p1;
   logic              vld_p1;
   logic              halt_fetched_q;

   if_fetch_stage_loader #(
      .NBITS     (NBITS),
      .MEM_DEPTH (MEM_DEPTH),
      .ADDR_W    (ADDR_W),
      .HALT_WORD (HALT_WORD)
   ) u_loader (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_load_start (i_load_start),
      .i_load_valid (i_load_valid),
      .i_load_byte  (i_load_byte),
      .o_we         (mem_we),
      .o_waddr      (mem_waddr),
      .o_wdata      (mem_wdata),
      .o_state      (state),
      .o_load_done  (o_load_done),
      .o_loading    (o_loading)
   );

   // Instruction memory write port; contents deliberately survive reset.
   always_ff @(posedge i_clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Upper PC bits are dropped so fetch addresses wrap around the memory.
   assign rd_word = mem[i_pc[ADDR_W-1:0]];

   assign run_ok   = (state == S_RUN) && i_enable && !i_halt;
   assign advance  = run_ok && !i_stall;
   assign flush_ok = run_ok && i_flush;
   assign pc_plus1 = i_pc + NBITS'(1);

   // Next PC; when not advancing the PC register holds, so the value is don't-care.
   always_comb begin
      o_next_pc = pc_plus1;
      if (advance && i_branch_taken) o_next_pc = i_branch_target;
   end

   // ---- IF -> ID boundary ----
   // IF/ID register: load start and flush insert a bubble, flush beats stall.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         instr_p1       <= '0;
         pc_plus1_p1    <= '0;
         vld_p1         <= 1'b0;
         halt_fetched_q <= 1'b0;
      end else if (i_load_start) begin
         instr_p1       <= NOP_INSTR;
         vld_p1         <= 1'b0;
         halt_fetched_q <= 1'b0;
      end else if (flush_ok) begin
         instr_p1 <= NOP_INSTR;
         vld_p1   <= 1'b0;
      end else if (advance) begin
         instr_p1    <= rd_word;
         pc_plus1_p1 <= pc_plus1;
         vld_p1      <= 1'b1;
         if (rd_word == HALT_WORD) halt_fetched_q <= 1'b1;
      end
   end

   assign o_instr        = instr_p1;
   assign o_pc_plus1     = pc_plus1_p1;
   assign o_valid        = vld_p1;
   assign o_halt_fetched = halt_fetched_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: stimulus pushes time-stamped expected
// values, a negedge monitor pops and compares them against the DUT.
module tb_if_fetch_stage;

   localparam int K_INSTR   = 0;
   localparam int K_PCP1    = 1;
   localparam int K_VALID   = 2;
   localparam int K_HALTF   = 3;
   localparam int K_DONE    = 4;
   localparam int K_LOADING = 5;
   localparam int K_NEXTPC  = 6;

   typedef struct {
      int          stamp;
      int          kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc     = 0;
   int   checks  = 0;
   int   errors  = 0;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_enable, i_halt, i_stall, i_flush;
   logic [31:0] i_pc, i_branch_target;
   logic        i_branch_taken;
   logic        i_load_start, i_load_valid;
   logic [7:0]  i_load_byte;
   logic [31:0] o_next_pc, o_instr, o_pc_plus1;
   logic        o_valid, o_halt_fetched, o_load_done, o_loading;

   if_fetch_stage dut (
      .i_clk           (i_clk),
      .i_reset         (i_reset),
      .i_enable        (i_enable),
      .i_halt          (i_halt),
      .i_stall         (i_stall),
      .i_flush         (i_flush),
      .i_pc            (i_pc),
      .i_branch_taken  (i_branch_taken),
      .i_branch_target (i_branch_target),
      .i_load_start    (i_load_start),
      .i_load_valid    (i_load_valid),
      .i_load_byte     (i_load_byte),
      .o_next_pc       (o_next_pc),
      .o_instr         (o_instr),
      .o_pc_plus1      (o_pc_plus1),
      .o_valid         (o_valid),
      .o_halt_fetched  (o_halt_fetched),
      .o_load_done     (o_load_done),
      .o_loading       (o_loading)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Monitor: compare every expectation stamped for the current cycle.
   always @(negedge i_clk) begin
      logic [31:0] act;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].stamp <= cyc) begin
            case (sb[i].kind)
               K_INSTR:   act = o_instr;
               K_PCP1:    act = o_pc_plus1;
               K_VALID:   act = {31'd0, o_valid};
               K_HALTF:   act = {31'd0, o_halt_fetched};
               K_DONE:    act = {31'd0, o_load_done};
               K_LOADING: act = {31'd0, o_loading};
               default:   act = o_next_pc;
            endcase
            checks++;
            if (sb[i].stamp < cyc) begin
               errors++;
               $display("FAIL %s: expectation for cycle %0d never sampled", sb[i].name, sb[i].stamp);
            end else if (act !== sb[i].val) begin
               errors++;
               $display("FAIL %s: got %h, expected %h (cycle %0d)", sb[i].name, act, sb[i].val, cyc);
            end
            sb.delete(i);
         end
      end
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic expect_at(input int kind, input int off, input logic [31:0] val, input string name);
      exp_t e;
      e.stamp = cyc + off;
      e.kind  = kind;
      e.val   = val;
      e.name  = name;
      sb.push_back(e);
   endtask

   // Drive one loader byte in its own cycle.
   task automatic send_byte(input logic [7:0] b);
      step();
      i_load_start = 1'b0;
      i_load_valid = 1'b1;
      i_load_byte  = b;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] prog [12];
      prog = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};

      i_reset = 1'b1; i_enable = 1'b0; i_halt = 1'b0; i_stall = 1'b0;
      i_flush = 1'b0; i_pc = '0; i_branch_taken = 1'b0; i_branch_target = '0;
      i_load_start = 1'b0; i_load_valid = 1'b0; i_load_byte = '0;

      // Reset state
      step(); step();
      expect_at(K_INSTR,   0, 32'h0, "rst_instr");
      expect_at(K_PCP1,    0, 32'h0, "rst_pc_plus1");
      expect_at(K_VALID,   0, 32'h0, "rst_valid");
      expect_at(K_HALTF,   0, 32'h0, "rst_halt_fetched");
      expect_at(K_DONE,    0, 32'h0, "rst_load_done");
      expect_at(K_LOADING, 0, 32'h0, "rst_loading");
      i_reset = 1'b0;
      step();
      i_enable = 1'b1;
      expect_at(K_VALID, 1, 32'h0, "idle_no_fetch");
      step();
      i_enable = 1'b0;

      // Program load: 1, 2, HALT
      step();
      i_load_start = 1'b1;
      expect_at(K_LOADING, 1, 32'h1, "load_loading");
      expect_at(K_VALID,   1, 32'h0, "load_bubble");
      for (int k = 0; k < 12; k++) begin
         send_byte(prog[k]);
         if (k == 10) begin
            expect_at(K_DONE,    1, 32'h0, "done_early");
            expect_at(K_LOADING, 1, 32'h1, "loading_before_last");
         end
         if (k == 11) begin
            expect_at(K_DONE,    1, 32'h1, "done_pulse");
            expect_at(K_LOADING, 1, 32'h0, "loading_fall");
            expect_at(K_DONE,    2, 32'h0, "done_one_cycle");
         end
      end
      step();
      i_load_valid = 1'b0;

      // Run
      step();
      i_enable = 1'b1; i_pc = 32'd0;
      expect_at(K_NEXTPC, 0, 32'd1, "next_pc_seq");
      expect_at(K_INSTR,  1, 32'd1, "fetch0_instr");
      expect_at(K_PCP1,   1, 32'd1, "fetch0_pcp1");
      expect_at(K_VALID,  1, 32'd1, "fetch0_valid");
      expect_at(K_HALTF,  1, 32'd0, "fetch0_no_halt");
      step();
      i_pc = 32'd1;
      expect_at(K_INSTR, 1, 32'd2, "fetch1_instr");
      expect_at(K_PCP1,  1, 32'd2, "fetch1_pcp1");
      step();
      i_pc = 32'd2;
      expect_at(K_NEXTPC, 0, 32'd3,         "next_pc_2");
      expect_at(K_INSTR,  1, 32'hFFFF_FFFF, "fetch2_halt_instr");
      expect_at(K_HALTF,  1, 32'd1,         "halt_fetched");

      // Stall holds, flush beats stall
      step();
      i_pc = 32'd1; i_stall = 1'b1;
      expect_at(K_INSTR, 1, 32'hFFFF_FFFF, "stall_hold_instr");
      expect_at(K_PCP1,  1, 32'd3,         "stall_hold_pcp1");
      expect_at(K_VALID, 1, 32'd1,         "stall_hold_valid");
      step();
      i_flush = 1'b1;
      expect_at(K_VALID, 1, 32'd0, "flush_valid");
      expect_at(K_INSTR, 1, 32'd0, "flush_instr");
      expect_at(K_HALTF, 1, 32'd1, "flush_keeps_halt");
      step();
      i_flush = 1'b0; i_stall = 1'b0;

      // Branch, wrap, address wrap, halt gating
      i_pc = 32'd0; i_branch_taken = 1'b1; i_branch_target = 32'h40;
      expect_at(K_NEXTPC, 0, 32'h40, "branch_target");
      expect_at(K_INSTR,  1, 32'd1,  "branch_cycle_fetch");
      step();
      i_branch_taken = 1'b0; i_pc = 32'h0000_0102;
      expect_at(K_INSTR, 1, 32'hFFFF_FFFF, "addr_wrap_instr");
      expect_at(K_PCP1,  1, 32'h0000_0103, "addr_wrap_pcp1");
      step();
      i_pc = 32'hFFFF_FFFF; i_stall = 1'b1;
      expect_at(K_NEXTPC, 0, 32'h0, "pc_wrap");
      step();
      i_branch_taken = 1'b1;
      expect_at(K_NEXTPC, 0, 32'h0, "stalled_branch_ignored");
      step();
      i_stall = 1'b0; i_branch_taken = 1'b0; i_halt = 1'b1; i_pc = 32'd0;
      expect_at(K_INSTR, 1, 32'hFFFF_FFFF, "halt_blocks_fetch");
      expect_at(K_PCP1,  1, 32'h0000_0103, "halt_holds_pcp1");
      step();
      i_halt = 1'b0; i_enable = 1'b0;

      // Restart mid-word: the colliding byte is dropped
      step();
      i_load_start = 1'b1;
      expect_at(K_LOADING, 1, 32'd1, "reload_loading");
      expect_at(K_VALID,   1, 32'd0, "reload_bubble");
      expect_at(K_INSTR,   1, 32'd0, "reload_instr_nop");
      expect_at(K_HALTF,   1, 32'd0, "reload_clears_halt");
      send_byte(8'hAA);
      send_byte(8'hBB);
      step();
      i_load_start = 1'b1; i_load_valid = 1'b1; i_load_byte = 8'h11;
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h07);
      send_byte(8'hFF);
      send_byte(8'hFF);
      send_byte(8'hFF);
      send_byte(8'hFF);
      expect_at(K_DONE, 1, 32'd1, "reload_done");
      step();
      i_load_valid = 1'b0;
      step();
      i_enable = 1'b1; i_pc = 32'd0;
      expect_at(K_INSTR, 1, 32'd7, "reload_mem0");
      step();
      i_pc = 32'd1;
      expect_at(K_INSTR, 1, 32'hFFFF_FFFF, "reload_mem1_halt");
      expect_at(K_HALTF, 1, 32'd1,         "reload_halt_fetched");
      step();
      i_enable = 1'b0;

      // Reset in the middle of a load
      step();
      i_load_start = 1'b1;
      send_byte(8'h12);
      send_byte(8'h34);
      step();
      i_load_valid = 1'b0; i_enable = 1'b1; i_reset = 1'b1;
      expect_at(K_LOADING, 0, 32'd0, "midrst_loading");
      expect_at(K_INSTR,   0, 32'd0, "midrst_instr");
      expect_at(K_PCP1,    0, 32'd0, "midrst_pcp1");
      expect_at(K_VALID,   0, 32'd0, "midrst_valid");
      expect_at(K_HALTF,   0, 32'd0, "midrst_halt");
      step();
      i_reset = 1'b0;
      expect_at(K_VALID, 1, 32'd0, "midrst_idle_enable");
      expect_at(K_DONE,  1, 32'd0, "midrst_no_done");
      step(); step(); step();

      foreach (sb[i]) begin
         errors++;
         $display("FAIL %s: expectation left unchecked", sb[i].name);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage around the PC register.
- Holds the instruction memory and a byte-wise program loader fed by the debug UART.
- Computes the next PC, which feeds the PC register's i_PC input.
- Latches the fetched instruction and PC+1 into the IF/ID pipeline register for decode.
- PC is word-indexed: sequential next PC = PC + 1.

Parameters:
- NBITS, 32, data/PC width
- MEM_DEPTH, 256, instruction memory depth in words
- ADDR_W, 8, memory address width; must equal log2(MEM_DEPTH)
- HALT_WORD, 32'hFFFF_FFFF, encoding of the HALT instruction

Ports:
- i_clk, in, 1, clock
- i_reset, in, 1, asynchronous active-high reset
- i_enable, in, 1, debug run/step enable
- i_halt, in, 1, global halt
- i_stall, in, 1, load-use stall from hazard unit
- i_flush, in, 1, branch/jump resolved taken in ID: squash IF/ID
- i_pc, in, NBITS, current PC (PC register's o_newPC)
- i_branch_taken, in, 1, select i_branch_target
- i_branch_target, in, NBITS, redirect target
- i_load_start, in, 1, begin program load
- i_load_valid, in, 1, load byte strobe
- i_load_byte, in, 8, load byte, MSB-first per word
- o_next_pc, out, NBITS, next PC to PC register
- o_instr, out, NBITS, IF/ID instruction
- o_pc_plus1, out, NBITS, IF/ID PC+1
- o_valid, out, 1, IF/ID holds a real instruction
- o_halt_fetched, out, 1, sticky: HALT_WORD latched into IF/ID
- o_load_done, out, 1, one-cycle pulse at end of load
- o_loading, out, 1, FSM in S_LOAD

Behaviour:
Reset values:
- FSM = S_IDLE.
- All outputs, the write pointer and the byte counter = 0.
- Memory contents are not reset.

Memory:
- Asynchronous read at i_pc[ADDR_W-1:0].
- PC bits above ADDR_W are ignored; addressing wraps.
- Synchronous write from the loader only.

FSM states: S_IDLE, S_LOAD, S_RUN.
- S_IDLE: fetch blocked.
- i_load_start in any state:
  - go to S_LOAD; wptr = 0, bcnt = 0
  - IF/ID becomes a bubble (o_instr = 0, o_valid = 0)
  - o_halt_fetched cleared
  - i_load_start has priority over a same-cycle i_load_valid; that byte is dropped.
- S_LOAD, per i_load_valid:
  - shift register <= {sr[23:0], byte}; bcnt++
  - on the 4th byte: mem[wptr] <= assembled word; wptr++; bcnt = 0
  - the write is never split by a stall
- Leave S_LOAD for S_RUN and pulse o_load_done when the word written equals HALT_WORD, or wptr == MEM_DEPTH-1 is written.
- S_RUN stays until reset or i_load_start.

Next PC (combinational), advance = S_RUN & i_enable & !i_halt & !i_stall:
- advance & i_branch_taken -> i_branch_target
- otherwise -> i_pc + 1, NBITS arithmetic, wraps to 0
- When not advancing, the value is irrelevant: the PC register holds.

IF/ID register (posedge or async reset), priority order:
1. Reset.
2. i_load_start -> bubble.
3. i_flush & S_RUN & i_enable & !i_halt -> bubble; flush beats stall.
4. advance -> o_instr = mem[i_pc], o_pc_plus1 = i_pc + 1, o_valid = 1.
5. Otherwise hold.

Halt and flags:
- o_halt_fetched set when HALT_WORD is latched with o_valid = 1.
- Fetch continues; upstream control asserts i_halt.
- o_loading = (state == S_LOAD).
- Reset mid-load aborts the load; partial words are discarded, already-written words remain.

Latency: IF/ID is valid 1 cycle after advance with PC p.

Decomposition:
- Shared package/header holds:
  - FSM state encodings
  - HALT_WORD
  - NOP constant (32'h0)
  - BYTES_PER_WORD = 4
- Natural sub-module: if_loader (byte assembler, write pointer, FSM).
- Memory and the IF/ID register stay in if_fetch_stage.

Test Plan:
1. Reset mid-operation -> all outputs 0, state S_IDLE; i_enable = 1 still gives o_valid = 0.
2. Load bytes 00 00 00 01, 00 00 00 02, FF FF FF FF -> mem[0..2] = 1, 2, FFFFFFFF; o_load_done pulses on the 12th byte; o_loading falls the same cycle.
3. Run: i_pc = 0, enable, no stall -> o_next_pc = 1; next cycle o_instr = 1, o_pc_plus1 = 1, o_valid = 1. Then i_pc = 2 -> o_halt_fetched = 1.
4. i_stall = 1 at i_pc = 1 -> IF/ID holds the previous value; with i_stall and i_flush together -> o_valid = 0, o_instr = 0.
5. i_branch_taken = 1, target 0x40 -> o_next_pc = 0x40. i_pc = 32'hFFFFFFFF with no branch -> o_next_pc = 0 (wrap).
6. i_load_start with i_load_valid after 2 bytes of a word -> bcnt = 0, wptr = 0, the byte is dropped; the next 4 bytes land in mem[0].
